// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Purpose  : Write-side companion to the instruction ROM. Zero-fills the
//             instruction memory, then accepts a program as a byte stream
//             over a valid/ready handshake. It packs the bytes into 32-bit
//             big-endian words and writes each word through the memory
//             write port. The CPU is held in reset for the whole load.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   1       rising-edge clock
//    reset       in   1       synchronous, active-high
//    start       in   1       1-cycle pulse; begins a load (IDLE/DONE only)
//    in_data     in   8       program byte; first byte of a word -> [31:24]
//    in_valid    in   1       in_data is valid
//    in_last     in   1       marks the final byte of the program
//    in_ready    out  1       loader accepts a byte this cycle
//    mem_we      out  1       instruction-memory write strobe
//    mem_addr    out  ADDR_W  word-aligned byte address of the write
//    mem_wdata   out  32      write data
//    cpu_hold    out  1       high for the whole load
//    done        out  1       load complete; held until start or reset
//    error       out  1       sticky: partial last word or overflow
//    word_count  out  32      program words written (zero-fill excluded)
// ============================================================================
module imem_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [31:0]       word_count
);

    // word index must be able to hold DEPTH itself to flag overflow
    localparam int                 c_IDX_W    = $clog2(DEPTH + 1);
    localparam int                 c_CLR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_CLR_W-1:0] c_CLR_LAST = c_CLR_W'(DEPTH - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_FULL = c_IDX_W'(DEPTH);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_CLEAR = 3'd1;
    localparam logic [2:0] c_RECV  = 3'd2;
    localparam logic [2:0] c_WRITE = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    logic [2:0]         r_state;
    logic [c_CLR_W-1:0] r_clr_idx;
    logic [c_IDX_W-1:0] r_word_idx;
    logic [1:0]         r_byte_cnt;
    logic [31:0]        r_word;
    logic               r_last;     // word being written ends the program
    logic               r_partial;  // word being written is short
    logic               r_error;
    logic [31:0]        r_word_count;

    logic               w_accept;
    logic               w_overflow;
    logic               w_wr_ok;
    logic [31:0]        w_word_next;

    assign w_accept   = in_valid && (r_state == c_RECV);
    assign w_overflow = (r_word_idx == c_IDX_FULL);
    assign w_wr_ok    = (r_state == c_WRITE) && !w_overflow;

    // Drop the incoming byte into its big-endian lane; lanes not yet filled
    // stay zero, which pads a short final word.
    always_comb begin
        w_word_next = r_word;
        case (r_byte_cnt)
            2'd0:    w_word_next[31:24] = in_data;
            2'd1:    w_word_next[23:16] = in_data;
            2'd2:    w_word_next[15:8]  = in_data;
            default: w_word_next[7:0]   = in_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_clr_idx    <= '0;
            r_word_idx   <= '0;
            r_byte_cnt   <= '0;
            r_word       <= '0;
            r_last       <= 1'b0;
            r_partial    <= 1'b0;
            r_error      <= 1'b0;
            r_word_count <= '0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (start) begin
                        r_state      <= c_CLEAR;
                        r_clr_idx    <= '0;
                        r_word_idx   <= '0;
                        r_byte_cnt   <= '0;
                        r_word       <= '0;
                        r_error      <= 1'b0;
                        r_word_count <= '0;
                    end
                end
                c_CLEAR: begin
                    if (r_clr_idx == c_CLR_LAST) begin
                        r_state <= c_RECV;
                    end else begin
                        r_clr_idx <= r_clr_idx + 1'b1;
                    end
                end
                c_RECV: begin
                    if (w_accept) begin
                        r_word     <= w_word_next;
                        r_byte_cnt <= r_byte_cnt + 1'b1;
                        if ((r_byte_cnt == 2'd3) || in_last) begin
                            r_state   <= c_WRITE;
                            r_last    <= in_last;
                            r_partial <= in_last && (r_byte_cnt != 2'd3);
                        end
                    end
                end
                c_WRITE: begin
                    // Past the end of memory the word is dropped but the
                    // source is still drained up to its last byte.
                    if (w_overflow) begin
                        r_error <= 1'b1;
                    end else begin
                        r_word_idx   <= r_word_idx + 1'b1;
                        r_word_count <= r_word_count + 32'd1;
                    end
                    if (r_partial) begin
                        r_error <= 1'b1;
                    end
                    r_word     <= '0;
                    r_byte_cnt <= '0;
                    r_state    <= r_last ? c_DONE : c_RECV;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready   = (r_state == c_RECV);
        cpu_hold   = (r_state == c_CLEAR) || (r_state == c_RECV) || (r_state == c_WRITE);
        done       = (r_state == c_DONE);
        error      = r_error;
        word_count = r_word_count;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (r_state == c_CLEAR) begin
            mem_we   = 1'b1;
            mem_addr = ADDR_W'({r_clr_idx, 2'b00});
        end else if (w_wr_ok) begin
            mem_we    = 1'b1;
            mem_addr  = ADDR_W'({r_word_idx, 2'b00});
            mem_wdata = r_word;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_loader
//  Purpose  : Self-checking bench for imem_loader. A cycle model of the
//             loader's observable behaviour is compared with the outputs on
//             every cycle; directed loads add literal expectations on the
//             written memory image and the status outputs.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_imem_loader;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 32;

    logic              clk      = 1'b0;
    logic              reset    = 1'b1;
    logic              start    = 1'b0;
    logic [7:0]        in_data  = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_last  = 1'b0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [31:0]       word_count;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .done(done),
        .error(error), .word_count(word_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- memory image captured from the write port ----------
    logic [31:0] dut_mem [DEPTH];
    int          n_writes = 0;
    int          n_oob    = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (mem_we === 1'b1) begin
                n_writes++;
                if (mem_addr < 4 * DEPTH) dut_mem[mem_addr >> 2] = mem_wdata;
                else n_oob++;
            end
        end
    end

    // ---------------- behavioural model + per-cycle compare --------------
    bit          m_valid = 0;
    bit          m_busy, m_done, m_err, m_wr, m_wr_last, m_wr_part;
    int          m_clr, m_widx, m_wcnt, m_nb;
    logic [31:0] m_word;

    initial begin
        bit          e_clearing, e_we, e_ready;
        logic [31:0] e_addr, e_wdata;
        forever begin
            @(negedge clk);
            e_clearing = (m_clr > 0);
            e_we       = e_clearing || (m_wr && m_widx < DEPTH);
            e_addr     = e_clearing ? 32'(4 * (DEPTH - m_clr)) : (e_we ? 32'(4 * m_widx) : 32'd0);
            e_wdata    = (!e_clearing && e_we) ? m_word : 32'd0;
            e_ready    = m_busy && !e_clearing && !m_wr;
            if (m_valid) begin
                chk("cyc_in_ready",   {31'd0, in_ready}, {31'd0, e_ready});
                chk("cyc_mem_we",     {31'd0, mem_we},   {31'd0, e_we});
                chk("cyc_mem_addr",   mem_addr,          e_addr);
                chk("cyc_mem_wdata",  mem_wdata,         e_wdata);
                chk("cyc_cpu_hold",   {31'd0, cpu_hold}, {31'd0, m_busy});
                chk("cyc_done",       {31'd0, done},     {31'd0, m_done});
                chk("cyc_error",      {31'd0, error},    {31'd0, m_err});
                chk("cyc_word_count", word_count,        32'(m_wcnt));
            end
            // advance the model across the coming rising edge
            if (reset) begin
                m_valid = 1; m_busy = 0; m_done = 0; m_err = 0; m_wr = 0;
                m_wr_last = 0; m_wr_part = 0; m_clr = 0; m_widx = 0;
                m_wcnt = 0; m_nb = 0; m_word = 0;
            end else if (m_valid) begin
                if (!m_busy) begin
                    if (start) begin
                        m_busy = 1; m_done = 0; m_err = 0; m_clr = DEPTH;
                        m_widx = 0; m_wcnt = 0; m_nb = 0; m_word = 0; m_wr = 0;
                    end
                end else if (m_clr > 0) begin
                    m_clr--;
                end else if (m_wr) begin
                    if (m_widx < DEPTH) begin m_widx++; m_wcnt++; end
                    else m_err = 1;
                    if (m_wr_part) m_err = 1;
                    m_wr = 0; m_nb = 0; m_word = 0;
                    if (m_wr_last) begin m_busy = 0; m_done = 1; end
                end else if (in_valid) begin
                    m_word = m_word | ({24'd0, in_data} << (8 * (3 - m_nb)));
                    m_nb++;
                    if (m_nb == 4 || in_last) begin
                        m_wr = 1; m_wr_last = in_last; m_wr_part = (m_nb < 4);
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one byte, optionally after idle cycles, and hold it until taken.
    task automatic send_byte(input logic [7:0] d, input bit last, input int stall);
        bit acc;
        int budget;
        if (stall > 0) begin
            in_valid = 1'b0;
            repeat (stall) tick();
        end
        in_valid = 1'b1; in_data = d; in_last = last;
        acc = 0; budget = 100;
        while (!acc && budget > 0) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            budget--;
        end
        if (!acc) chk("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input string name);
        int budget;
        budget = 50;
        in_valid = 1'b0; in_last = 1'b0;
        while (done !== 1'b1 && budget > 0) begin
            tick();
            budget--;
        end
        chk(name, {31'd0, done}, 32'd1);
    endtask

    logic [7:0] t3_bytes [8] = '{8'h20, 8'ha5, 8'h00, 8'h0a, 8'h0c, 8'h00, 8'h00, 8'h03};
    logic [7:0] t4_bytes [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic [7:0] t6_bytes [8] = '{8'hde, 8'had, 8'hbe, 8'hef, 8'h01, 8'h02, 8'h03, 8'h04};

    initial begin
        int w0, clr_run;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // 1: reset state
        chk("rst_in_ready",   {31'd0, in_ready}, 32'd0);
        chk("rst_mem_we",     {31'd0, mem_we},   32'd0);
        chk("rst_cpu_hold",   {31'd0, cpu_hold}, 32'd0);
        chk("rst_done",       {31'd0, done},     32'd0);
        chk("rst_error",      {31'd0, error},    32'd0);
        chk("rst_word_count", word_count,        32'd0);

        // 2: zero-fill sweep; a byte is already offered and must not be taken
        in_valid = 1'b1; in_data = 8'h20; in_last = 1'b0;
        w0 = n_writes;
        pulse_start();
        clr_run = 0;
        while (mem_we === 1'b1 && clr_run < 40) begin
            chk("t2_clear_addr",  mem_addr,  32'(4 * clr_run));
            chk("t2_clear_wdata", mem_wdata, 32'd0);
            chk("t2_clear_hold",  {31'd0, cpu_hold}, 32'd1);
            clr_run++;
            tick();
        end
        chk("t2_clear_len", 32'(clr_run), 32'd32);
        chk("t2_ready_after_clear", {31'd0, in_ready}, 32'd1);

        // 3: two full words
        foreach (t3_bytes[i]) send_byte(t3_bytes[i], i == 7, 0);
        wait_done("t3_done");
        chk("t3_mem0",       dut_mem[0], 32'h20a5000a);
        chk("t3_mem1",       dut_mem[1], 32'h0c000003);
        chk("t3_mem2",       dut_mem[2], 32'h00000000);
        chk("t3_word_count", word_count, 32'd2);
        chk("t3_error",      {31'd0, error},    32'd0);
        chk("t3_cpu_hold",   {31'd0, cpu_hold}, 32'd0);
        chk("t3_writes",     32'(n_writes - w0), 32'd34);
        chk("t3_model_wcnt", 32'(m_wcnt), 32'd2);

        // 4: restart from DONE, short final word
        w0 = n_writes;
        pulse_start();
        chk("t4_done_drops", {31'd0, done},     32'd0);
        chk("t4_hold_rises", {31'd0, cpu_hold}, 32'd1);
        foreach (t4_bytes[i]) send_byte(t4_bytes[i], i == 5, 0);
        wait_done("t4_done");
        chk("t4_mem0",       dut_mem[0], 32'h11223344);
        chk("t4_mem1",       dut_mem[1], 32'h55660000);
        chk("t4_error",      {31'd0, error}, 32'd1);
        chk("t4_word_count", word_count, 32'd2);
        chk("t4_writes",     32'(n_writes - w0), 32'd34);

        // 5: 33 words into a 32-word memory
        w0 = n_writes;
        pulse_start();
        for (int i = 0; i < 132; i++) send_byte(8'(i), i == 131, 0);
        wait_done("t5_done");
        chk("t5_writes",     32'(n_writes - w0), 32'd64);
        chk("t5_oob",        32'(n_oob), 32'd0);
        chk("t5_mem0",       dut_mem[0],  32'h00010203);
        chk("t5_mem31",      dut_mem[31], 32'h7c7d7e7f);
        chk("t5_error",      {31'd0, error}, 32'd1);
        chk("t5_word_count", word_count, 32'd32);

        // 6: reset in the middle of RECV with the source still valid
        pulse_start();
        for (int i = 0; i < 10; i++) send_byte(8'(8'ha0 + i), 1'b0, int'($urandom_range(0, 2)));
        in_valid = 1'b1; in_data = 8'hff; in_last = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rst_ready", {31'd0, in_ready}, 32'd0);
        chk("t6_rst_hold",  {31'd0, cpu_hold}, 32'd0);
        chk("t6_rst_done",  {31'd0, done},     32'd0);
        chk("t6_rst_err",   {31'd0, error},    32'd0);
        chk("t6_rst_wcnt",  word_count,        32'd0);
        chk("t6_keep_mem0", dut_mem[0], 32'ha0a1a2a3);
        chk("t6_keep_mem1", dut_mem[1], 32'ha4a5a6a7);
        tick();
        chk("t6_idle_ignores_last", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0; in_last = 1'b0;
        tick();
        pulse_start();
        foreach (t6_bytes[i]) send_byte(t6_bytes[i], i == 7, int'($urandom_range(0, 3)));
        wait_done("t6_done");
        chk("t6_mem0",       dut_mem[0], 32'hdeadbeef);
        chk("t6_mem1",       dut_mem[1], 32'h01020304);
        chk("t6_mem2",       dut_mem[2], 32'h00000000);
        chk("t6_word_count", word_count, 32'd2);
        chk("t6_error",      {31'd0, error}, 32'd0);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // absolute guard against a stuck run
    initial begin
        #500000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
